// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game score/timer block and display mux
// Contents:
//   game_state_e  - IDLE / PLAY / OVER state encoding
//   BCD_DIGITS    - number of packed BCD score digits
//   DISP_W, LED_W - display data and LED bar widths shared with the display mux
//   lives_therm() - lives count to LED thermometer pattern
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam int BCD_DIGITS = 4;
  localparam int DISP_W     = 16;
  localparam int LED_W      = 16;

  // Bit i is set iff i < lives, so lives=3 gives 16'h0007 and lives=16 gives 16'hFFFF.
  function automatic logic [LED_W-1:0] lives_therm(input logic [4:0] lives);
    logic [LED_W-1:0] t;
    t = '0;
    for (int i = 0; i < LED_W; i++) begin
      t[i] = (i < int'(lives));
    end
    return t;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - saturating packed-BCD up counter used for the score
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr_i      - synchronous clear to all zeros (wins over inc_i)
//   inc_i      - add one with ripple carry across digits; holds at all nines
//   bcd_o      - registered packed BCD value, most significant digit in the top nibble
module bcd_counter4
  import game_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  logic [BCD_DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic                       all_nine;
  logic                       carry;

  always_comb begin
    cnt_d    = cnt_q;
    all_nine = 1'b1;
    carry    = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (cnt_q[i] != 4'd9) all_nine = 1'b0;
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !all_nine) begin
      // Carry enters the units digit and ripples up through every digit sitting at 9.
      carry = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (carry) begin
          if (cnt_q[i] == 4'd9) begin
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bcd_o = cnt_q;

endmodule

// File: rtl/game_score_timer.sv
// rtl/game_score_timer.sv - round timer, lives and BCD score keeper for the game mode
// Parameters:
//   CLK_HZ    - clock cycles per one-second tick
//   ROUND_SEC - round length in seconds (1..127)
//   LIVES     - starting lives (1..16)
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   enable     - game mode selected; low forces IDLE on the next clock
//   hit, miss  - one-cycle pulses: +1 score, -1 life
//   seg_data   - score as 4 packed BCD digits
//   led        - lives thermometer in PLAY, one-second blink in OVER
//   time_left  - remaining round seconds
//   game_over  - high while in OVER
module game_score_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int ROUND_SEC = 60,
  parameter int LIVES     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              hit,
  input  logic              miss,
  output logic [DISP_W-1:0] seg_data,
  output logic [LED_W-1:0]  led,
  output logic [6:0]        time_left,
  output logic              game_over
);

  localparam int                TICK_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX   = TICK_W'(CLK_HZ - 1);
  localparam logic [4:0]        LIVES_INIT = 5'(LIVES);
  localparam logic [6:0]        ROUND_INIT = 7'(ROUND_SEC);

  game_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [4:0]        lives_q, lives_d;
  logic [6:0]        time_q, time_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              over_q, over_d;
  logic              tick_wrap;
  logic              score_clr;
  logic              score_inc;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    lives_d   = lives_q;
    time_d    = time_q;
    led_d     = led_q;
    over_d    = over_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    tick_wrap = (tick_q == TICK_MAX);

    if (!enable) begin
      state_d   = ST_IDLE;
      tick_d    = '0;
      lives_d   = '0;
      time_d    = '0;
      led_d     = '0;
      over_d    = 1'b0;
      score_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Entry cycle: load a fresh round; pulses in this cycle are dropped.
          state_d   = ST_PLAY;
          tick_d    = '0;
          lives_d   = LIVES_INIT;
          time_d    = ROUND_INIT;
          led_d     = lives_therm(LIVES_INIT);
          over_d    = 1'b0;
          score_clr = 1'b1;
        end
        ST_PLAY: begin
          if (lives_q == 5'd0 || time_q == 7'd0) begin
            // Restart the tick so the first all-on blink phase lasts a full second.
            state_d = ST_OVER;
            over_d  = 1'b1;
            led_d   = '1;
            tick_d  = '0;
          end else begin
            tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
            if (tick_wrap) time_d = time_q - 7'd1;
            if (miss) lives_d = lives_q - 5'd1;
            led_d     = lives_therm(lives_d);
            score_inc = hit;
          end
        end
        ST_OVER: begin
          tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
          if (tick_wrap) led_d = ~led_q;
          over_d = 1'b1;
        end
        default: begin
          state_d   = ST_IDLE;
          tick_d    = '0;
          lives_d   = '0;
          time_d    = '0;
          led_d     = '0;
          over_d    = 1'b0;
          score_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      lives_q <= '0;
      time_q  <= '0;
      led_q   <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      lives_q <= lives_d;
      time_q  <= time_d;
      led_q   <= led_d;
      over_q  <= over_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (score_clr),
    .inc_i (score_inc),
    .bcd_o (seg_data)
  );

  assign led       = led_q;
  assign time_left = time_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_game_score_timer.sv
// tb/tb_game_score_timer.sv - self-checking bench for game_score_timer
module tb_game_score_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_s, hit_s, miss_s, en_b, hit_b, miss_b;
  logic [15:0] seg_s, led_s, seg_b, led_b;
  logic [6:0]  tl_s, tl_b;
  logic        go_s, go_b;

  always #5 clk = ~clk;

  game_score_timer #(.CLK_HZ(10), .ROUND_SEC(3), .LIVES(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .hit(hit_s), .miss(miss_s),
    .seg_data(seg_s), .led(led_s), .time_left(tl_s), .game_over(go_s)
  );

  game_score_timer #(.CLK_HZ(1000), .ROUND_SEC(127), .LIVES(4)) dut_big (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .hit(hit_b), .miss(miss_b),
    .seg_data(seg_b), .led(led_b), .time_left(tl_b), .game_over(go_b)
  );

  typedef struct {
    string       name;
    bit          big;
    logic [15:0] seg;
    logic [15:0] led;
    logic [6:0]  tl;
    bit          chk_tl;
    logic        go;
  } exp_t;

  typedef struct {
    logic        en;
    logic        hit;
    logic        miss;
    logic [15:0] seg;
    logic [15:0] led;
    logic [6:0]  tl;
    logic        go;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input string n, input bit big, input logic [15:0] seg,
                              input logic [15:0] led, input logic [6:0] tl,
                              input bit chk_tl, input logic go);
    exp_t e;
    e.name = n; e.big = big; e.seg = seg; e.led = led;
    e.tl = tl; e.chk_tl = chk_tl; e.go = go;
    return e;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic vec_t mv(input logic en, input logic hit, input logic miss,
                              input logic [15:0] seg, input logic [15:0] led,
                              input logic [6:0] tl, input logic go);
    vec_t v;
    v.en = en; v.hit = hit; v.miss = miss; v.seg = seg; v.led = led; v.tl = tl; v.go = go;
    return v;
  endfunction

  task automatic check_pop();
    exp_t        e;
    logic [15:0] as, al;
    logic [6:0]  at;
    logic        ag;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e  = sb.pop_front();
    as = e.big ? seg_b : seg_s;
    al = e.big ? led_b : led_s;
    at = e.big ? tl_b  : tl_s;
    ag = e.big ? go_b  : go_s;
    if (as !== e.seg || al !== e.led || ag !== e.go || (e.chk_tl && at !== e.tl)) begin
      n_fail++;
      $display("FAIL %s: got seg=%h led=%h tl=%0d go=%b, want seg=%h led=%h tl=%0d go=%b",
               e.name, as, al, at, ag, e.seg, e.led, e.tl, e.go);
    end
  endtask

  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en_s = 1'b0; hit_s = 1'b0; miss_s = 1'b0;
    en_b = 1'b0; hit_b = 1'b0; miss_b = 1'b0;

    // Expected state after the clock edge that consumes each row's inputs.
    vecs[0]  = mv(0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[1]  = mv(1, 1, 0, 16'h0000, 16'h000F, 3, 0);
    vecs[2]  = mv(1, 1, 0, 16'h0001, 16'h000F, 3, 0);
    vecs[3]  = mv(1, 1, 0, 16'h0002, 16'h000F, 3, 0);
    vecs[4]  = mv(1, 0, 1, 16'h0002, 16'h0007, 3, 0);
    vecs[5]  = mv(1, 1, 1, 16'h0003, 16'h0003, 3, 0);
    vecs[6]  = mv(1, 0, 0, 16'h0003, 16'h0003, 3, 0);
    vecs[7]  = mv(1, 0, 0, 16'h0003, 16'h0003, 3, 0);
    vecs[8]  = mv(1, 0, 0, 16'h0003, 16'h0003, 3, 0);
    vecs[9]  = mv(1, 0, 0, 16'h0003, 16'h0003, 3, 0);
    vecs[10] = mv(1, 0, 0, 16'h0003, 16'h0003, 3, 0);
    vecs[11] = mv(1, 1, 1, 16'h0004, 16'h0001, 2, 0);
    vecs[12] = mv(1, 0, 1, 16'h0004, 16'h0000, 2, 0);
    vecs[13] = mv(1, 0, 0, 16'h0004, 16'hFFFF, 2, 1);
    vecs[14] = mv(1, 1, 1, 16'h0004, 16'hFFFF, 2, 1);

    repeat (2) @(negedge clk);
    sb.push_back(mk("reset_small", 0, 16'h0000, 16'h0000, 0, 1, 0)); check_pop();
    sb.push_back(mk("reset_big",   1, 16'h0000, 16'h0000, 0, 1, 0)); check_pop();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      en_s = vecs[i].en; hit_s = vecs[i].hit; miss_s = vecs[i].miss;
      step(mk($sformatf("vec%0d", i), 0, vecs[i].seg, vecs[i].led, vecs[i].tl, 1, vecs[i].go));
    end

    // OVER blink: entry was after vec13, each phase is 10 clocks, pulses are ignored.
    for (int k = 15; k <= 40; k++) begin
      hit_s = k[0]; miss_s = ~k[0];
      step(mk($sformatf("blink%0d", k), 0, 16'h0004,
              (((k - 13) / 10) % 2 == 0) ? 16'hFFFF : 16'h0000, 2, 1, 1));
    end
    hit_s = 1'b0; miss_s = 1'b0;

    en_s = 1'b0;
    step(mk("over_to_idle", 0, 16'h0000, 16'h0000, 0, 1, 0));
    en_s = 1'b1;
    step(mk("fresh_round", 0, 16'h0000, 16'h000F, 3, 1, 0));

    // Idle countdown to timeout.
    for (int k = 1; k <= 31; k++) begin
      step(mk($sformatf("countdown%0d", k), 0, 16'h0000,
              (k >= 31) ? 16'hFFFF : 16'h000F, 7'(3 - k / 10), 1, (k >= 31)));
    end

    en_s = 1'b0;
    step(mk("disable_mid", 0, 16'h0000, 16'h0000, 0, 1, 0));
    en_s = 1'b1;
    step(mk("restart", 0, 16'h0000, 16'h000F, 3, 1, 0));
    hit_s = 1'b1;
    step(mk("hit_before_rst", 0, 16'h0001, 16'h000F, 3, 1, 0));
    hit_s = 1'b0;

    // Asynchronous reset between clock edges, released with enable still high.
    rst_n = 1'b0;
    #1;
    sb.push_back(mk("async_reset", 0, 16'h0000, 16'h0000, 0, 1, 0)); check_pop();
    #1;
    rst_n = 1'b1;
    step(mk("restart_after_rst", 0, 16'h0000, 16'h000F, 3, 1, 0));
    hit_s = 1'b1;
    step(mk("hit_after_rst", 0, 16'h0001, 16'h000F, 3, 1, 0));
    hit_s = 1'b0;
    en_s = 1'b0;
    step(mk("small_off", 0, 16'h0000, 16'h0000, 0, 1, 0));

    // Score ripple and saturation on the long-round instance.
    en_b = 1'b1;
    step(mk("big_entry", 1, 16'h0000, 16'h000F, 127, 1, 0));
    hit_b = 1'b1;
    for (int n = 1; n <= 10050; n++) begin
      step(mk($sformatf("big_hit%0d", n), 1, to_bcd(n), 16'h000F, 0, 0, 0));
    end
    hit_b = 1'b0;
    en_b = 1'b0;
    step(mk("big_off", 1, 16'h0000, 16'h0000, 0, 1, 0));
    en_b = 1'b1;
    step(mk("big_entry2", 1, 16'h0000, 16'h000F, 127, 1, 0));

    // Build score 0041 with one life, then hit+miss in the same cycle.
    hit_b = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      step(mk($sformatf("pre_hit%0d", n), 1, to_bcd(n), 16'h000F, 0, 0, 0));
    end
    hit_b = 1'b0; miss_b = 1'b1;
    step(mk("pre_miss1", 1, 16'h0041, 16'h0007, 0, 0, 0));
    step(mk("pre_miss2", 1, 16'h0041, 16'h0003, 0, 0, 0));
    step(mk("pre_miss3", 1, 16'h0041, 16'h0001, 0, 0, 0));
    hit_b = 1'b1;
    step(mk("hit_miss_same", 1, 16'h0042, 16'h0000, 0, 0, 0));
    hit_b = 1'b0; miss_b = 1'b0;
    step(mk("over_after_last_life", 1, 16'h0042, 16'hFFFF, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_score_timer.md
GAME_SCORE_TIMER -- requirements
Module: game_score_timer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clock cycles per one-second tick.
REQ-002 Parameter ROUND_SEC, default 60, round length in seconds (1..127).
REQ-003 Parameter LIVES, default 8, starting lives (1..16).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  game mode selected (level); drives this block and the display mux downstream.
REQ-007 hit  in  1  one-cycle pulse, +1 score.
REQ-008 miss  in  1  one-cycle pulse, -1 life.
REQ-009 seg_data  out  16  score as 4 packed BCD digits, [15:12] thousands .. [3:0] units; feeds the seg_classic/seg_infinity input of the display mux.
REQ-010 led  out  16  lives thermometer / game-over blink; feeds the display mux led input.
REQ-011 time_left  out  7  remaining round seconds, binary.
REQ-012 game_over  out  1  high while in state OVER.

Function
REQ-013 FSM states IDLE, PLAY, OVER; all outputs registered.
REQ-014 IDLE: seg_data=0, led=0, time_left=0, game_over=0, tick counter held at 0.
REQ-015 IDLE -> PLAY on enable=1; entry cycle loads score=0000, lives=LIVES, time_left=ROUND_SEC, tick counter=0.
REQ-016 Any state -> IDLE on enable=0, effective next cycle; enable=0 has priority over every other event.
REQ-017 PLAY: tick counter counts 0..CLK_HZ-1, wraps; at wrap time_left decrements by 1.
REQ-018 PLAY: hit increments score in BCD, carries ripple across digits (0009->0010, 0999->1000); saturates at 9999, no wrap.
REQ-019 PLAY: miss decrements lives; lives never underflow below 0.
REQ-020 led in PLAY = thermometer of lives: bit i set iff i < lives (lives=3 -> 16'h0007).
REQ-021 hit, miss and tick in the same cycle all apply in that cycle.
REQ-022 PLAY -> OVER in the cycle after lives or time_left becomes 0; score updates from the cycle that caused it are kept.
REQ-023 OVER: score, time_left frozen; hit/miss ignored; game_over=1; led=16'hFFFF for one second, 16'h0000 the next, repeating (tick counter keeps running), starting with all on.
REQ-024 OVER -> PLAY only via IDLE (enable must drop and rise again).
REQ-025 Output latency: seg_data/led reflect a hit/miss one clock after the pulse.
REQ-026 hit/miss while in IDLE or on the IDLE->PLAY entry cycle are ignored.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE with all outputs and internal counters 0.
REQ-028 Reset release mid-round does not resume; block waits in IDLE and needs enable=1 to start (enable already high restarts PLAY on first clock after release).

Structure
REQ-029 Shared package game_pkg holds the state enum, BCD_DIGITS=4, and the 16-bit display/led width constants used by the display mux as well.
REQ-030 Sub-module bcd_counter4: synchronous clear, increment enable, saturating 4-digit BCD output; instantiated once for the score.
REQ-031 Tick counter width = clog2(CLK_HZ); no other clock enables or derived clocks.

Verification (CLK_HZ=10, ROUND_SEC=3, LIVES=4)
REQ-032 enable 0->1, no pulses -> led=16'h000F, time_left 3,2,1,0 every 10 clocks, game_over=1 one clock after time_left=0.
REQ-033 Preload via 999 hits with large ROUND_SEC then 1 hit -> seg_data=16'h1000; 9000 more hits -> stays 16'h9999.
REQ-034 4 miss pulses -> led 000F,0007,0003,0001,0000, then OVER, led blinks FFFF/0000 at 10-clock intervals, seg_data frozen.
REQ-035 hit and miss same cycle with lives=1, score=0041 -> score 0042, lives 0, OVER next cycle, seg_data=16'h0042.
REQ-036 rst_n low mid-PLAY asynchronously -> all outputs 0 immediately; enable=0 mid-PLAY -> IDLE next clock, outputs 0.
REQ-037 In OVER, pulse enable 0 for 1 cycle then 1 -> fresh round: score 0000, led 000F, time_left 3.
